mux32_sel_seq: RTL and testbench

Sequencer that drives the 5-bit select of the 32:1 operand mux feeding the pe_array.
- Accepts one configuration descriptor: base lane, stride, length, repeat count.
- Walks the lane schedule and presents each select to the consumer over a valid/ready handshake.
- Converts logical lane index to the mux's inverted select encoding (sel = 31 - lane).
- Flags the end of each pass and of the whole job.

---
 rtl/mux32_pkg.sv | 25 ++
 rtl/mux32_lane_gen.sv | 75 +++++++
 rtl/mux32_sel_seq.sv | 125 ++++++++++++
 tb/tb_mux32_sel_seq.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/mux32_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mux32_pkg
// Brief    : Shared constants, FSM state type and select-encoding helper for
//            drivers of the 32:1 operand mux.
// Revision : 1.0  initial release
// ============================================================================
package mux32_pkg;

    localparam int MUX32_LANES = 32;
    localparam int MUX32_SEL_W = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } mux32_state_t;

    // The mux is wired in reverse order: lane 0 sits on select 31.
    function automatic logic [MUX32_SEL_W-1:0] lane_to_sel(input logic [MUX32_SEL_W-1:0] lane);
        return ~lane;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mux32_lane_gen.sv
`default_nettype none
// ============================================================================
// Module   : mux32_lane_gen
// Brief    : Lane schedule generator; holds the descriptor, current lane and
//            element/pass counters and flags the end of pass and job.
// Revision : 1.0  initial release
// ============================================================================
module mux32_lane_gen
    import mux32_pkg::*;
#(
    parameter int REP_W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_load,
    input  logic                   i_step,
    input  logic [MUX32_SEL_W-1:0] i_base,
    input  logic [MUX32_SEL_W-1:0] i_stride,
    input  logic [MUX32_SEL_W-1:0] i_len_m1,
    input  logic [REP_W-1:0]       i_rep_m1,
    output logic [MUX32_SEL_W-1:0] o_lane,
    output logic                   o_pass_last,
    output logic                   o_job_last
);

    logic [MUX32_SEL_W-1:0] r_base;
    logic [MUX32_SEL_W-1:0] r_stride;
    logic [MUX32_SEL_W-1:0] r_len_m1;
    logic [REP_W-1:0]       r_rep_m1;
    logic [MUX32_SEL_W-1:0] r_lane;
    logic [MUX32_SEL_W-1:0] r_elem_cnt;
    logic [REP_W-1:0]       r_pass_cnt;

    logic w_pass_last;
    logic w_job_last;

    assign w_pass_last = (r_elem_cnt == r_len_m1);
    assign w_job_last  = w_pass_last && (r_pass_cnt == r_rep_m1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_base     <= '0;
            r_stride   <= '0;
            r_len_m1   <= '0;
            r_rep_m1   <= '0;
            r_lane     <= '0;
            r_elem_cnt <= '0;
            r_pass_cnt <= '0;
        end else if (i_load) begin
            r_base     <= i_base;
            r_stride   <= i_stride;
            r_len_m1   <= i_len_m1;
            r_rep_m1   <= i_rep_m1;
            r_lane     <= i_base;
            r_elem_cnt <= '0;
            r_pass_cnt <= '0;
        end else if (i_step && !w_job_last) begin
            if (w_pass_last) begin
                // Every pass restarts at the base lane.
                r_elem_cnt <= '0;
                r_pass_cnt <= r_pass_cnt + 1'b1;
                r_lane     <= r_base;
            end else begin
                r_elem_cnt <= r_elem_cnt + 1'b1;
                r_lane     <= r_lane + r_stride;
            end
        end
    end

    assign o_lane      = r_lane;
    assign o_pass_last = w_pass_last;
    assign o_job_last  = w_job_last;

endmodule
`default_nettype wire

// File: rtl/mux32_sel_seq.sv
`default_nettype none
// ============================================================================
// Module   : mux32_sel_seq
// Brief    : Select sequencer for the 32:1 operand mux feeding the pe_array.
//            Optional abort support: define MUX32_SEL_SEQ_ABORT_EN.
// Revision : 1.0  initial release
// ============================================================================
module mux32_sel_seq
    import mux32_pkg::*;
#(
    parameter int LANES = 32,
    parameter int REP_W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cfg_valid,
    output logic                   cfg_ready,
    input  logic [MUX32_SEL_W-1:0] cfg_base,
    input  logic [MUX32_SEL_W-1:0] cfg_stride,
    input  logic [MUX32_SEL_W-1:0] cfg_len_m1,
    input  logic [REP_W-1:0]       cfg_rep_m1,
    output logic                   sel_valid,
    input  logic                   sel_ready,
    output logic [MUX32_SEL_W-1:0] sel_o,
    output logic [MUX32_SEL_W-1:0] lane_o,
    output logic                   pass_last,
    output logic                   job_last,
    output logic                   busy,
`ifdef MUX32_SEL_SEQ_ABORT_EN
    input  logic                   abort,
    output logic                   aborted,
`endif
    output logic                   done
);

    generate
        if (LANES != MUX32_LANES) begin : g_lanes_check
            $error("mux32_sel_seq: LANES must be 32");
        end
    endgenerate

    mux32_state_t r_state;
    mux32_state_t w_state_nxt;

    logic                   w_cfg_fire;
    logic                   w_sel_fire;
    logic                   w_abort;
    logic                   w_step;
    logic [MUX32_SEL_W-1:0] w_lane;
    logic                   w_pass_last;
    logic                   w_job_last;

    assign w_cfg_fire = cfg_valid && cfg_ready;
    assign w_sel_fire = sel_valid && sel_ready;

`ifdef MUX32_SEL_SEQ_ABORT_EN
    logic r_aborted;

    assign w_abort = abort && (r_state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_aborted <= 1'b0;
        end else begin
            r_aborted <= w_abort;
        end
    end

    assign aborted = r_aborted;
`else
    assign w_abort = 1'b0;
`endif

    // An abort coinciding with the final fire suppresses the step and DONE.
    assign w_step = w_sel_fire && !w_abort;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_cfg_fire)               w_state_nxt = ST_RUN;
            ST_RUN:  if (w_sel_fire && w_job_last) w_state_nxt = ST_DONE;
            ST_DONE:                               w_state_nxt = ST_IDLE;
            default:                               w_state_nxt = ST_IDLE;
        endcase
        if (w_abort) begin
            w_state_nxt = ST_IDLE;
        end
    end

    mux32_lane_gen #(
        .REP_W (REP_W)
    ) u_lane_gen (
        .clk         (clk),
        .rst         (rst),
        .i_load      (w_cfg_fire),
        .i_step      (w_step),
        .i_base      (cfg_base),
        .i_stride    (cfg_stride),
        .i_len_m1    (cfg_len_m1),
        .i_rep_m1    (cfg_rep_m1),
        .o_lane      (w_lane),
        .o_pass_last (w_pass_last),
        .o_job_last  (w_job_last)
    );

    assign cfg_ready = (r_state == ST_IDLE);
    assign sel_valid = (r_state == ST_RUN);
    assign busy      = (r_state != ST_IDLE);
    assign done      = (r_state == ST_DONE);
    assign lane_o    = w_lane;
    assign sel_o     = lane_to_sel(w_lane);
    // Counter compares are only meaningful while a select is on offer.
    assign pass_last = sel_valid && w_pass_last;
    assign job_last  = sel_valid && w_job_last;

endmodule
`default_nettype wire

// File: tb/tb_mux32_sel_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux32_sel_seq
// Brief    : Self-checking bench for mux32_sel_seq against a schedule model.
// Revision : 1.0  initial release
// ============================================================================
module tb_mux32_sel_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cfg_valid = 1'b0;
    logic       cfg_ready;
    logic [4:0] cfg_base = '0;
    logic [4:0] cfg_stride = '0;
    logic [4:0] cfg_len_m1 = '0;
    logic [7:0] cfg_rep_m1 = '0;
    logic       sel_valid;
    logic       sel_ready = 1'b0;
    logic [4:0] sel_o;
    logic [4:0] lane_o;
    logic       pass_last;
    logic       job_last;
    logic       busy;
    logic       done;
`ifdef MUX32_SEL_SEQ_ABORT_EN
    logic       abort = 1'b0;
    logic       aborted;
`endif

    mux32_sel_seq #(
        .LANES (32),
        .REP_W (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_base   (cfg_base),
        .cfg_stride (cfg_stride),
        .cfg_len_m1 (cfg_len_m1),
        .cfg_rep_m1 (cfg_rep_m1),
        .sel_valid  (sel_valid),
        .sel_ready  (sel_ready),
        .sel_o      (sel_o),
        .lane_o     (lane_o),
        .pass_last  (pass_last),
        .job_last   (job_last),
        .busy       (busy),
`ifdef MUX32_SEL_SEQ_ABORT_EN
        .abort      (abort),
        .aborted    (aborted),
`endif
        .done       (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int lane;
        bit pl;
        bit jl;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_cfg_ready"}, 32'(cfg_ready), 1);
        chk({tag, "_sel_valid"}, 32'(sel_valid), 0);
        chk({tag, "_sel_o"},     32'(sel_o),     31);
        chk({tag, "_lane_o"},    32'(lane_o),    0);
        chk({tag, "_pass_last"}, 32'(pass_last), 0);
        chk({tag, "_job_last"},  32'(job_last),  0);
        chk({tag, "_busy"},      32'(busy),      0);
        chk({tag, "_done"},      32'(done),      0);
    endtask

    // Expected schedule straight from the descriptor: pass-major, element-minor.
    task automatic build_model(input int b, input int s, input int l, input int r);
        exp_t e;
        q.delete();
        for (int p = 0; p <= r; p++) begin
            for (int k = 0; k <= l; k++) begin
                e.lane = (b + k * s) % 32;
                e.pl   = (k == l);
                e.jl   = (k == l) && (p == r);
                q.push_back(e);
            end
        end
    endtask

    // mode: 0 = ready always high, 1 = ready pattern 1,0,0,1, 2 = random ready.
    // stop_after >= 0 leaves the job in RUN after that many fires.
    task automatic run_job(input int b, input int s, input int l, input int r,
                           input int mode, input bit hold_cfg, input int stop_after);
        int cyc;
        int fires;
        int budget;
        bit rdy;
        build_model(b, s, l, r);
        budget = q.size() * 8 + 20;
        @(negedge clk);
        chk("cfg_ready_idle", 32'(cfg_ready), 1);
        cfg_valid  = 1'b1;
        cfg_base   = 5'(b);
        cfg_stride = 5'(s);
        cfg_len_m1 = 5'(l);
        cfg_rep_m1 = 8'(r);
        @(negedge clk);
        if (hold_cfg) begin
            cfg_base   = 5'(b + 1);
            cfg_stride = 5'(s + 2);
            cfg_len_m1 = 5'(l + 3);
        end else begin
            cfg_valid = 1'b0;
        end
        cyc   = 0;
        fires = 0;
        while (q.size() > 0 && cyc < budget) begin
            if (fires == stop_after) break;
            chk("sel_valid_run", 32'(sel_valid), 1);
            chk("cfg_ready_run", 32'(cfg_ready), 0);
            chk("busy_run",      32'(busy),      1);
            chk("lane_o",        32'(lane_o),    32'(q[0].lane));
            chk("sel_o",         32'(sel_o),     32'(31 - q[0].lane));
            chk("pass_last",     32'(pass_last), 32'(q[0].pl));
            chk("job_last",      32'(job_last),  32'(q[0].jl));
            case (mode)
                1:       rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
                2:       rdy = ($urandom % 2) == 1;
                default: rdy = 1'b1;
            endcase
            sel_ready = rdy;
            if (rdy) begin
                void'(q.pop_front());
                fires++;
            end
            cyc++;
            @(negedge clk);
        end
        sel_ready = 1'b0;
        if (fires == stop_after) return;
        chk("job_timeout_left", 32'(q.size()), 0);
        chk("done_pulse",     32'(done),      1);
        chk("busy_done",      32'(busy),      1);
        chk("sel_valid_done", 32'(sel_valid), 0);
        chk("cfg_ready_done", 32'(cfg_ready), 0);
        cfg_valid = 1'b0;
        @(negedge clk);
        chk("done_clear",     32'(done),      0);
        chk("busy_idle",      32'(busy),      0);
        chk("cfg_ready_back", 32'(cfg_ready), 1);
        chk("sel_valid_idle", 32'(sel_valid), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk_reset_vals("reset");
        rst = 1'b0;

        run_job(0, 1, 31, 0, 0, 1'b0, -1);
        run_job(30, 3, 3, 1, 0, 1'b0, -1);
        run_job(30, 3, 3, 1, 1, 1'b0, -1);
        run_job(5, 0, 2, 0, 0, 1'b1, -1);

        run_job(0, 1, 31, 0, 0, 1'b0, 4);
        rst = 1'b1;
        @(negedge clk);
        chk_reset_vals("mid_run_reset");
        rst = 1'b0;
        run_job(7, 5, 4, 2, 2, 1'b0, -1);

`ifdef MUX32_SEL_SEQ_ABORT_EN
        run_job(0, 1, 31, 0, 0, 1'b0, 2);
        sel_ready = 1'b1;
        abort     = 1'b1;
        @(negedge clk);
        sel_ready = 1'b0;
        abort     = 1'b0;
        chk("aborted_pulse",   32'(aborted),   1);
        chk("abort_no_done",   32'(done),      0);
        chk("abort_sel_valid", 32'(sel_valid), 0);
        chk("abort_cfg_ready", 32'(cfg_ready), 1);
        @(negedge clk);
        chk("aborted_clear",   32'(aborted),   0);
        chk("abort_no_done2",  32'(done),      0);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_idle_noop", 32'(aborted),   0);
`endif

        for (int j = 0; j < 6; j++) begin
            run_job(int'($urandom % 32), int'($urandom % 32), int'($urandom % 8),
                    int'($urandom % 4), 2, 1'b0, -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
